iter_muldiv: RTL and testbench

ITER_MULDIV -- requirements
Module: iter_muldiv

---
 rtl/iter_muldiv_if.sv | 27 ++
 rtl/iter_muldiv.sv | 177 +++++++++++++++++
 tb/tb_iter_muldiv.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_muldiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// master = issuing pipeline stage, slave = the unit itself.
interface iter_muldiv_if #(
  parameter int XLEN = 64
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [2:0]      funct3_i;
  logic            word_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  modport master (
    output in_valid_i, funct3_i, word_i, op1_i, op2_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, busy_o
  );

  modport slave (
    input  in_valid_i, funct3_i, word_i, op1_i, op2_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/iter_muldiv.sv
// Iterative RV64/RV32 M-extension unit: one shift-add (multiply) or one
// restoring-subtract (divide) step per cycle on operand magnitudes, with sign
// correction applied on the final step. Divide-by-zero, signed overflow and
// word-width high multiplies complete one cycle after acceptance.
module iter_muldiv #(
  parameter int XLEN = 64
) (
  input logic          clk,
  input logic          rst,
  iter_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [6:0]          cnt;
  logic [2:0]          op;
  logic                word;
  logic                neg;
  logic [XLEN-1:0]     divisor;   // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0]   acc;       // {hi, multiplier} or {remainder, quotient}
  logic [XLEN-1:0]     result;

  // Request decode (combinational on the bus inputs, used only on accept)
  logic                accept;
  logic                w_in;
  logic                is_div;
  logic                s1;
  logic                s2;
  logic [XLEN-1:0]     a_ext;
  logic [XLEN-1:0]     b_ext;
  logic                a_neg;
  logic                b_neg;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;
  logic                div0;
  logic                ovf;
  logic                mulh_w;
  logic                fast;
  logic [XLEN-1:0]     dividend_res;
  logic [XLEN-1:0]     min_val;
  logic [XLEN-1:0]     fast_res;

  // Iteration step and completion
  logic [XLEN:0]       sum;
  logic [XLEN:0]       top;
  logic [XLEN+1:0]     diff;
  logic [XLEN-1:0]     rem_new;
  logic                qbit;
  logic [2*XLEN-1:0]   acc_next;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     dval;
  logic [XLEN-1:0]     fin;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v,
                                          input logic w, input logic sgn);
    logic [XLEN-1:0] r;
    r = v;
    if (w) begin
      r       = sgn ? {XLEN{v[31]}} : '0;
      r[31:0] = v[31:0];
    end
    return r;
  endfunction

  assign accept = bus.in_valid_i & (state == IDLE) & ~bus.flush_i;
  assign w_in   = (XLEN == 64) & bus.word_i;
  assign is_div = bus.funct3_i[2];

  // Operand preparation: width selection, signedness, magnitudes, fast paths
  always_comb begin : in_decode
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    s1           = is_div ? ~bus.funct3_i[0]
                          : (bus.funct3_i[1:0] == 2'b01) | (bus.funct3_i[1:0] == 2'b10);
    s2           = is_div ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] == 2'b01);
    a_ext        = ext(bus.op1_i, w_in, s1);
    b_ext        = ext(bus.op2_i, w_in, s2);
    a_neg        = s1 & a_ext[XLEN-1];
    b_neg        = s2 & b_ext[XLEN-1];
    a_mag        = a_neg ? -a_ext : a_ext;
    b_mag        = b_neg ? -b_ext : b_ext;
    min_val      = '0;
    min_val[XLEN-1] = 1'b1;
    if (w_in) min_val = sext32(32'h8000_0000);
    div0         = is_div & (b_ext == '0);
    ovf          = is_div & s1 & (a_ext == min_val) & (b_ext == '1);
    mulh_w       = ~is_div & w_in & (bus.funct3_i[1:0] != 2'b00);
    fast         = div0 | ovf | mulh_w;
    dividend_res = w_in ? sext32(bus.op1_i[31:0]) : bus.op1_i;
    fast_res     = '0;
    if (div0)     fast_res = bus.funct3_i[1] ? dividend_res : '1;
    else if (ovf) fast_res = bus.funct3_i[1] ? '0 : dividend_res;
  end

  // One multiply or divide iteration on the current accumulator
  always_comb begin : step
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, divisor};
    top     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = {1'b0, top} - {2'b00, divisor};
    qbit    = ~diff[XLEN+1];
    rem_new = qbit ? diff[XLEN-1:0] : top[XLEN-1:0];
    if (op[2])       acc_next = {rem_new, acc[XLEN-2:0], qbit};
    else if (acc[0]) acc_next = {sum, acc[XLEN-1:1]};
    else             acc_next = {1'b0, acc[2*XLEN-1:1]};
  end

  // Sign correction and result selection from the post-step accumulator
  always_comb begin : finish
    prod = word ? (acc_next >> (XLEN - 32)) : acc_next;
    if (neg) prod = -prod;
    dval = op[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    if (neg) dval = -dval;
    if (op[2])                 fin = word ? sext32(dval[31:0]) : dval;
    else if (op[1:0] == 2'b00) fin = word ? sext32(prod[31:0]) : prod[XLEN-1:0];
    else                       fin = prod[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush returns to IDLE from any state
  always_comb begin : fsm_next
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = fast ? DONE : CALC;
      CALC:    if (cnt == 7'd1) state_next = DONE;
      DONE:    if (bus.out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush_i) state_next = IDLE;
  end

  // Datapath: load on accept, iterate in CALC, register result on last step
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset too, so result_o reads 0 out of reset.
    if (rst) begin
      cnt     <= '0;
      op      <= '0;
      word    <= 1'b0;
      neg     <= 1'b0;
      divisor <= '0;
      acc     <= '0;
      result  <= '0;
    end else if (accept) begin
      op      <= bus.funct3_i;
      word    <= w_in;
      neg     <= (is_div & bus.funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
      divisor <= is_div ? b_mag : a_mag;
      acc     <= is_div ? {{XLEN{1'b0}}, (w_in ? (a_mag << (XLEN - 32)) : a_mag)}
                        : {{XLEN{1'b0}}, b_mag};
      cnt     <= fast ? 7'd0 : (w_in ? 7'd32 : 7'(XLEN));
      if (fast) result <= fast_res;
    end else if (state == CALC && !bus.flush_i) begin
      acc <= acc_next;
      cnt <= cnt - 7'd1;
      if (cnt == 7'd1) result <= fin;
    end
  end

  assign bus.in_ready_o  = (state == IDLE);
  assign bus.out_valid_o = (state == DONE);
  assign bus.busy_o      = (state != IDLE);
  assign bus.result_o    = result;

endmodule

// File: tb/tb_iter_muldiv.sv
// Scoreboard bench for iter_muldiv (XLEN=64): the driver pushes expected
// results and latencies, a negedge monitor pops and compares on each output.
module tb_iter_muldiv;

  localparam int          LIMIT = 200;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] res;
    int          edges;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   was_valid = 1'b0;
  exp_t sb[$];

  iter_muldiv_if #(.XLEN(64)) bus ();

  iter_muldiv #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: plain 128/64/32-bit arithmetic on the architectural rules.
  function automatic void ref_model(input logic [2:0] f, input logic w,
                                    input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] res, output int edges);
    logic [31:0]          a32, b32, r32;
    logic signed [31:0]   sa32, sb32;
    logic signed [63:0]   sa, sb;
    logic [127:0]         pu;
    logic signed [127:0]  ps;
    bit                   fast;
    fast = 1'b0;
    res  = '0;
    if (!w) begin
      sa = a;
      sb = b;
      case (f)
        3'd0: begin pu = {64'b0, a} * {64'b0, b}; res = pu[63:0]; end
        3'd1: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); res = ps[127:64]; end
        3'd2: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); res = ps[127:64]; end
        3'd3: begin pu = {64'b0, a} * {64'b0, b}; res = pu[127:64]; end
        3'd4: if (b == 0) begin res = ONES; fast = 1; end
              else if (a == MIN64 && b == ONES) begin res = a; fast = 1; end
              else res = sa / sb;
        3'd5: if (b == 0) begin res = ONES; fast = 1; end else res = a / b;
        3'd6: if (b == 0) begin res = a; fast = 1; end
              else if (a == MIN64 && b == ONES) begin res = 0; fast = 1; end
              else res = sa % sb;
        default: if (b == 0) begin res = a; fast = 1; end else res = a % b;
      endcase
      edges = fast ? 0 : 64;
    end else begin
      a32 = a[31:0];
      b32 = b[31:0];
      sa32 = a32;
      sb32 = b32;
      r32 = '0;
      case (f)
        3'd0: r32 = a32 * b32;
        3'd1, 3'd2, 3'd3: begin r32 = 0; fast = 1; end
        3'd4: if (b32 == 0) begin r32 = '1; fast = 1; end
              else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin r32 = a32; fast = 1; end
              else r32 = sa32 / sb32;
        3'd5: if (b32 == 0) begin r32 = '1; fast = 1; end else r32 = a32 / b32;
        3'd6: if (b32 == 0) begin r32 = a32; fast = 1; end
              else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin r32 = 0; fast = 1; end
              else r32 = sa32 % sb32;
        default: if (b32 == 0) begin r32 = a32; fast = 1; end else r32 = a32 % b32;
      endcase
      res   = {{32{r32[31]}}, r32};
      edges = fast ? 0 : 32;
    end
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0:       v = 64'd0;
      1:       v = ONES;
      2:       v = MIN64;
      3:       v = 64'($urandom_range(0, 20));
      4:       v = {32'($urandom), 32'h8000_0000};
      5:       v = {32'($urandom), 32'hFFFF_FFFF};
      default: v = {32'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  // Monitor: compare result and latency on the first cycle of each output
  always @(negedge clk) begin
    if (bus.out_valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 64'(bus.out_valid_o), 64'd0);
      end else begin
        if (!was_valid) begin
          check("result", bus.result_o, sb[0].res);
          check("latency", 64'(cyc - sb[0].cyc), 64'(sb[0].edges));
        end
        if (bus.out_ready_i) void'(sb.pop_front());
      end
    end
    was_valid = bus.out_valid_o & ~bus.out_ready_i;
  end

  // Present a request, wait until accepted, then scramble the inputs
  task automatic start_op(input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
    int guard;
    @(posedge clk); #1;
    bus.funct3_i   = f;
    bus.word_i     = w;
    bus.op1_i      = a;
    bus.op2_i      = b;
    bus.in_valid_i = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready_o && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", 64'(guard >= LIMIT), 64'd0);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    bus.funct3_i   = 3'($urandom);
    bus.word_i     = 1'($urandom);
    bus.op1_i      = {32'($urandom), 32'($urandom)};
    bus.op2_i      = {32'($urandom), 32'($urandom)};
  endtask

  task automatic run_op(input logic [2:0] f, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_edges, input bit rnd_ready);
    exp_t e;
    int   guard;
    start_op(f, w, a, b);
    e.res   = exp_res;
    e.edges = exp_edges;
    e.cyc   = cyc;
    sb.push_back(e);
    guard = 0;
    while (sb.size() != 0 && guard < LIMIT) begin
      bus.out_ready_i = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    check("result_timeout", 64'(guard >= LIMIT), 64'd0);
    sb.delete();
    bus.out_ready_i = 1'b1;
  endtask

  task automatic run_rand(input bit rnd_ready);
    logic [2:0]  f;
    logic        w;
    logic [63:0] a, b, r;
    int          e;
    f = 3'($urandom);
    w = 1'($urandom);
    a = rand_operand();
    b = rand_operand();
    ref_model(f, w, a, b, r, e);
    run_op(f, w, a, b, r, e, rnd_ready);
  endtask

  initial begin
    exp_t e;
    int   guard;
    rst = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.funct3_i    = '0;
    bus.word_i      = 1'b0;
    bus.op1_i       = '0;
    bus.op2_i       = '0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    #12;
    check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_result", bus.result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases with hand-derived constants
    run_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, 1'b0);
    run_op(3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64, 1'b0);
    run_op(3'd1, 1'b0, ONES, ONES, 64'd0, 64, 1'b0);
    run_op(3'd5, 1'b0, 64'd100, 64'd0, ONES, 0, 1'b0);
    run_op(3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 0, 1'b0);
    run_op(3'd4, 1'b0, MIN64, ONES, MIN64, 0, 1'b0);
    run_op(3'd6, 1'b0, MIN64, ONES, 64'd0, 0, 1'b0);
    run_op(3'd4, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 1'b0);
    run_op(3'd6, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, ONES, 32, 1'b0);
    run_op(3'd3, 1'b1, ONES, ONES, 64'd0, 0, 1'b0);
    run_op(3'd5, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0001, ONES, 32, 1'b0);
    run_op(3'd2, 1'b0, ONES, 64'd2, ONES, 64, 1'b0);

    // Back-pressure: result and valid held while out_ready_i is low
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    start_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    e.res = 64'hFFFF_FFFF_FFFF_FFEB;
    e.edges = 64;
    e.cyc = cyc;
    sb.push_back(e);
    guard = 0;
    @(negedge clk);
    while (!bus.out_valid_o && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    check("stall_timeout", 64'(guard >= LIMIT), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_result", bus.result_o, 64'hFFFF_FFFF_FFFF_FFEB);
      check("stall_valid", 64'(bus.out_valid_o), 64'd1);
      check("stall_in_ready", 64'(bus.in_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("post_hs_valid", 64'(bus.out_valid_o), 64'd0);
    sb.delete();

    // Flush at CALC cycle 10: no result, unit ready next cycle
    start_op(3'd5, 1'b0, ONES, 64'd3);
    repeat (9) @(posedge clk);
    #1;
    check("calc_busy", 64'(bus.busy_o), 64'd1);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("flush_busy", 64'(bus.busy_o), 64'd0);
    repeat (80) @(posedge clk);

    // Asynchronous reset at CALC cycle 20
    start_op(3'd4, 1'b0, ONES, 64'd5);
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("arst_busy", 64'(bus.busy_o), 64'd0);
    check("arst_result", bus.result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (80) @(posedge clk);
    run_op(3'd5, 1'b0, 64'd9, 64'd2, 64'd4, 64, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) run_rand(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
